// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: CH-channel arbiter in front of one shared synchronous
// memory with a 1-cycle registered read, fixed-priority or round-robin.
//
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   req/we/lock [CH]    per-channel request, write strobe, grant lock
//   addr [CH*AW]        per-channel address, channel i at [i*AW +: AW]
//   wdata [CH*DW]       per-channel write data, channel i at [i*DW +: DW]
//   ack [CH]            combinational one-hot grant (accept = req & ack)
//   rvalid [CH]         one-hot read-return strobe, 2 cycles after accept
//   rdata [DW]          read data (mem_q passthrough)
//   mem_a/mem_d/mem_we  registered memory address, write data, write enable
//   mem_q [DW]          memory read data, valid the cycle after mem_a
module mem_arbiter_n #(
   parameter int CH   = 2,
   parameter int AW   = 16,
   parameter int DW   = 8,
   parameter int MODE = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [CH-1:0]    req,
   input  logic [CH-1:0]    we,
   input  logic [CH-1:0]    lock,
   input  logic [CH*AW-1:0] addr,
   input  logic [CH*DW-1:0] wdata,
   output logic [CH-1:0]    ack,
   output logic [CH-1:0]    rvalid,
   output logic [DW-1:0]    rdata,
   output logic [AW-1:0]    mem_a,
   output logic [DW-1:0]    mem_d,
   output logic             mem_we,
   input  logic [DW-1:0]    mem_q
);

   localparam int IW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [CH-1:0] ONE = {{(CH-1){1'b0}}, 1'b1};

   logic [IW-1:0] r_rr;
   logic [IW-1:0] r_own;
   logic          r_own_v;
   logic [AW-1:0] r_mem_a;
   logic [DW-1:0] r_mem_d;
   logic          r_mem_we;
   logic          r_s1_v;
   logic [IW-1:0] r_s1_ch;
   logic          r_s2_v;
   logic [IW-1:0] r_s2_ch;

   logic          w_lock_hit;
   logic          w_found;
   logic [IW-1:0] w_gsel;
   logic [IW-1:0] w_cand;

   // Lock holds only for the channel accepted on the previous edge,
   // and only while it still drives both lock and req.
   assign w_lock_hit = r_own_v & lock[r_own] & req[r_own];

   always_comb begin
      w_found = 1'b0;
      w_gsel  = '0;
      w_cand  = '0;
      if (w_lock_hit) begin
         w_found = 1'b1;
         w_gsel  = r_own;
      end else if (MODE == 0) begin
         for (int i = 0; i < CH; i++) begin
            if (!w_found && req[i]) begin
               w_found = 1'b1;
               w_gsel  = IW'(i);
            end
         end
      end else begin
         // Search starts one past the last normally granted channel.
         for (int k = 0; k < CH; k++) begin
            w_cand = IW'((int'(r_rr) + 1 + k) % CH);
            if (!w_found && req[w_cand]) begin
               w_found = 1'b1;
               w_gsel  = w_cand;
            end
         end
      end
   end

   assign ack    = w_found ? (ONE << w_gsel) : '0;
   assign rvalid = r_s2_v ? (ONE << r_s2_ch) : '0;
   assign rdata  = mem_q;
   assign mem_a  = r_mem_a;
   assign mem_d  = r_mem_d;
   assign mem_we = r_mem_we;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr     <= IW'(CH - 1);
         r_own    <= '0;
         r_own_v  <= 1'b0;
         r_mem_a  <= '0;
         r_mem_d  <= '0;
         r_mem_we <= 1'b0;
         r_s1_v   <= 1'b0;
         r_s1_ch  <= '0;
         r_s2_v   <= 1'b0;
         r_s2_ch  <= '0;
      end else begin
         r_own_v <= w_found;
         if (w_found) begin
            r_own <= w_gsel;
         end
         // Locked wins leave the round-robin pointer alone.
         if (w_found && !w_lock_hit) begin
            r_rr <= w_gsel;
         end
         if (w_found) begin
            r_mem_a  <= addr[int'(w_gsel)*AW +: AW];
            r_mem_d  <= wdata[int'(w_gsel)*DW +: DW];
            r_mem_we <= we[w_gsel];
         end else begin
            r_mem_we <= 1'b0;
         end
         r_s1_v  <= w_found & ~we[w_gsel];
         r_s1_ch <= w_gsel;
         r_s2_v  <= r_s1_v;
         r_s2_ch <= r_s1_ch;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench for mem_arbiter_n, one fixed-priority
// 2-channel instance and one round-robin 3-channel instance.
module tb_mem_arbiter_n;

   logic        clock;
   logic        reset_n;

   logic [1:0]  a_req, a_we, a_lock, a_ack, a_rvalid;
   logic [31:0] a_addr;
   logic [15:0] a_wdata;
   logic [7:0]  a_rdata, a_md, a_mq;
   logic [15:0] a_ma;
   logic        a_mwe;

   logic [2:0]  b_req, b_we, b_lock, b_ack, b_rvalid;
   logic [47:0] b_addr;
   logic [23:0] b_wdata;
   logic [7:0]  b_rdata, b_md, b_mq;
   logic [15:0] b_ma;
   logic        b_mwe;

   logic [7:0]  mem0 [0:65535];

   int n_tests;
   int n_fail;

   mem_arbiter_n #(.CH(2), .AW(16), .DW(8), .MODE(0)) u0 (
      .clock(clock), .reset_n(reset_n),
      .req(a_req), .we(a_we), .lock(a_lock),
      .addr(a_addr), .wdata(a_wdata),
      .ack(a_ack), .rvalid(a_rvalid), .rdata(a_rdata),
      .mem_a(a_ma), .mem_d(a_md), .mem_we(a_mwe), .mem_q(a_mq)
   );

   mem_arbiter_n #(.CH(3), .AW(16), .DW(8), .MODE(1)) u1 (
      .clock(clock), .reset_n(reset_n),
      .req(b_req), .we(b_we), .lock(b_lock),
      .addr(b_addr), .wdata(b_wdata),
      .ack(b_ack), .rvalid(b_rvalid), .rdata(b_rdata),
      .mem_a(b_ma), .mem_d(b_md), .mem_we(b_mwe), .mem_q(b_mq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!reset_n) begin
         mem0[16'h0010] <= 8'hA1;
         mem0[16'h0020] <= 8'hB2;
         for (int i = 0; i < 8; i++) mem0[i] <= 8'h30 + 8'(i);
      end else if (a_mwe) begin
         mem0[a_ma] <= a_md;
      end
      a_mq <= mem0[a_ma];
      b_mq <= b_ma[7:0] ^ 8'h5A;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      a_req = '0; a_we = '0; a_lock = '0; a_addr = '0; a_wdata = '0;
      b_req = '0; b_we = '0; b_lock = '0; b_wdata = '0;
      b_addr = {16'h0003, 16'h0002, 16'h0001};
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // reset state
      check("rst_ack_a", 32'(a_ack), 32'h0);
      check("rst_ack_b", 32'(b_ack), 32'h0);
      check("rst_rvalid", 32'(a_rvalid), 32'h0);
      check("rst_mem_a", 32'(a_ma), 32'h0);
      check("rst_mem_d", 32'(a_md), 32'h0);
      check("rst_mem_we", 32'(a_mwe), 32'h0);

      // fixed priority, both channels reading
      a_req  = 2'b11;
      a_addr = {16'h0020, 16'h0010};
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         check("fp_ack", 32'(a_ack), (c < 4) ? 32'h1 : 32'h0);
         check("fp_rvalid", 32'(a_rvalid),
               (c >= 2 && c < 6) ? 32'h1 : 32'h0);
         if (c >= 2 && c < 6) check("fp_rdata", 32'(a_rdata), 32'hA1);
         tick();
         if (c == 3) a_req = 2'b00;
      end

      // round robin, all three requesting
      b_req = 3'b111;
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         check("rr_ack", 32'(b_ack), (c < 6) ? (32'h1 << (c % 3)) : 32'h0);
         tick();
         if (c == 5) b_req = 3'b000;
      end

      // round robin lock on channel 2
      b_req  = 3'b100;
      b_lock = 3'b100;
      @(negedge clock);
      check("lk_first", 32'(b_ack), 32'h4);
      tick();
      b_req = 3'b111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("lk_hold", 32'(b_ack), 32'h4);
         tick();
      end
      b_lock = 3'b000;
      @(negedge clock);
      check("lk_rel", 32'(b_ack), 32'h1);
      tick();
      @(negedge clock);
      check("lk_next", 32'(b_ack), 32'h2);
      tick();
      b_req = 3'b000;

      // fixed priority lock: channel 1 holds over channel 0
      a_addr = {16'h0020, 16'h0010};
      a_req  = 2'b10;
      a_lock = 2'b10;
      @(negedge clock);
      check("fplk_first", 32'(a_ack), 32'h2);
      tick();
      a_req = 2'b11;
      @(negedge clock);
      check("fplk_hold", 32'(a_ack), 32'h2);
      tick();
      a_lock = 2'b00;
      @(negedge clock);
      check("fplk_rel", 32'(a_ack), 32'h1);
      tick();
      a_req = 2'b00;
      repeat (3) tick();

      // write then read same address on consecutive accepts
      a_req   = 2'b01;
      a_we    = 2'b01;
      a_addr  = {16'h0000, 16'h0300};
      a_wdata = {8'h00, 8'h5A};
      @(negedge clock);
      check("wr_ack", 32'(a_ack), 32'h1);
      tick();
      a_req  = 2'b10;
      a_we   = 2'b00;
      a_addr = {16'h0300, 16'h0000};
      @(negedge clock);
      check("rd_ack", 32'(a_ack), 32'h2);
      check("wr_mem_we", 32'(a_mwe), 32'h1);
      check("wr_mem_a", 32'(a_ma), 32'h0300);
      check("wr_mem_d", 32'(a_md), 32'h5A);
      tick();
      a_req = 2'b00;
      @(negedge clock);
      check("wr_we_once", 32'(a_mwe), 32'h0);
      check("wr_no_rv", 32'(a_rvalid), 32'h0);
      tick();
      @(negedge clock);
      check("rw_rvalid", 32'(a_rvalid), 32'h2);
      check("rw_rdata", 32'(a_rdata), 32'h5A);
      tick();
      @(negedge clock);
      check("rw_rv_end", 32'(a_rvalid), 32'h0);
      tick();

      // 8 back-to-back reads on one channel
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            a_req  = 2'b01;
            a_addr = {16'h0000, 16'(c)};
         end else begin
            a_req = 2'b00;
         end
         @(negedge clock);
         check("b2b_rvalid", 32'(a_rvalid),
               (c >= 2 && c < 10) ? 32'h1 : 32'h0);
         if (c >= 2 && c < 10)
            check("b2b_rdata", 32'(a_rdata), 32'h30 + 32'(c - 2));
         tick();
      end

      // reset while a read is in flight
      a_req  = 2'b01;
      a_addr = {16'h0000, 16'h0010};
      @(negedge clock);
      check("rr_pre_ack", 32'(a_ack), 32'h1);
      tick();
      a_req = 2'b00;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("rst_mid_mem_a", 32'(a_ma), 32'h0);
      check("rst_mid_rv", 32'(a_rvalid), 32'h0);
      check("rst_mid_we", 32'(a_mwe), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("rst_no_rv", 32'(a_rvalid), 32'h0);
      end

      // mem_we drops as soon as reset asserts
      tick();
      a_req   = 2'b01;
      a_we    = 2'b01;
      a_addr  = {16'h0000, 16'h0060};
      a_wdata = {8'h00, 8'h11};
      tick();
      a_req = 2'b00;
      a_we  = 2'b00;
      check("arst_we_pre", 32'(a_mwe), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_we", 32'(a_mwe), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // first grants after reset
      tick();
      a_req = 2'b11;
      b_req = 3'b111;
      @(negedge clock);
      check("post_rst_a", 32'(a_ack), 32'h1);
      check("post_rst_b", 32'(b_ack), 32'h1);
      tick();
      a_req = 2'b00;
      b_req = 3'b000;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
